// File: rtl/data_memory_ctrl.sv
// Word-organised data memory behind valid/ready request and response channels, one access in flight.
// Define DMEM_BYTE_WRITE_EN to add the req_wstrb port and per-byte store masking.
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
  logic [NBYTES-1:0]       wstrb_q;
`endif
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_err_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    access_err;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    do_write;

  // Range check: every address bit above the word-index field must be zero.
  assign access_err = ((addr_q & ALIGN_MASK) != '0) ||
                      ((addr_q >> (OFF + DEPTH_LOG2)) != '0);
  assign word_idx   = addr_q[OFF +: DEPTH_LOG2];
  assign do_write   = (state_q == ACCESS) && write_q && !access_err;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef DMEM_BYTE_WRITE_EN
      wstrb_q      <= '0;
`endif
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
            wstrb_q <= req_wstrb;
`endif
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= access_err;
          resp_rdata_q <= (write_q || access_err) ? '0 : mem_q[word_idx];
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset during ACCESS leaves state_q in IDLE so the store is dropped.
`ifdef DMEM_BYTE_WRITE_EN
  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wstrb_q[b]) mem_q[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (do_write) mem_q[word_idx] <= wdata_q;
  end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (default 32-bit, 8-word build); byte-strobe checks
// are compiled in when DMEM_BYTE_WRITE_EN is defined.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  req_wstrb = 4'hF;
`endif
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH_LOG2(3), .ADDR_WIDTH(32)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_wstrb  (req_wstrb),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full access with resp_ready high: handshake at edge N, response after N+1, consumed at N+2.
  task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rdata,
                           input logic exp_err);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
    check({tag, " early_valid"}, 32'(resp_valid), 32'd0);
    tick();
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
    tick();
    check({tag, " done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " done_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    tick();

    // Known contents for later checks
    do_access("init w0", 1'b1, 32'h00, 32'hCAFEF00D, 32'd0, 1'b0);
    do_access("init w1", 1'b1, 32'h04, 32'h00000000, 32'd0, 1'b0);
    do_access("init w2", 1'b1, 32'h08, 32'h11223344, 32'd0, 1'b0);

    do_access("st 1C", 1'b1, 32'h1C, 32'hDEADBEEF, 32'd0, 1'b0);
    do_access("ld 1C", 1'b0, 32'h1C, 32'h0, 32'hDEADBEEF, 1'b0);

    do_access("ld 1E misalign", 1'b0, 32'h1E, 32'h0, 32'd0, 1'b1);
    do_access("st 20 range", 1'b1, 32'h20, 32'h55555555, 32'd0, 1'b1);
    do_access("ld 00 intact", 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0);
    do_access("ld 08 base", 1'b0, 32'h08, 32'h0, 32'h11223344, 1'b0);

    // Back-pressure with req_valid held; address switches to the second request once accepted
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h1C;
    tick();
    req_addr = 32'h00;
    check("bp acc req_ready", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 32'(resp_valid), 32'd1);
      check("bp hold rdata", resp_rdata, 32'hDEADBEEF);
      check("bp hold err", 32'(resp_err), 32'd0);
      check("bp hold req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp idle valid", 32'(resp_valid), 32'd0);
    check("bp idle req_ready", 32'(req_ready), 32'd1);
    tick();
    check("bp 2nd accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    tick();
    check("bp 2nd valid", 32'(resp_valid), 32'd1);
    check("bp 2nd rdata", resp_rdata, 32'hCAFEF00D);
    tick();
    check("bp 2nd done", 32'(resp_valid), 32'd0);

    // Reset while the store sits in ACCESS
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h04;
    req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    check("rstmid in access", 32'(req_ready), 32'd0);
    #2 RSTN = 1'b0;
    #1;
    check("rstmid req_ready", 32'(req_ready), 32'd1);
    check("rstmid resp_valid", 32'(resp_valid), 32'd0);
    tick();
    tick();
    RSTN = 1'b1;
    tick();
    do_access("rstmid ld 04", 1'b0, 32'h04, 32'h0, 32'h00000000, 1'b0);

`ifdef DMEM_BYTE_WRITE_EN
    req_wstrb = 4'b0101;
    do_access("be st 0101", 1'b1, 32'h08, 32'hAABBCCDD, 32'd0, 1'b0);
    req_wstrb = 4'hF;
    do_access("be ld 08", 1'b0, 32'h08, 32'h0, 32'h11BB33DD, 1'b0);
    req_wstrb = 4'h0;
    do_access("be st 0000", 1'b1, 32'h08, 32'hFFFFFFFF, 32'd0, 1'b0);
    do_access("be ld strb0", 1'b0, 32'h08, 32'h0, 32'h11BB33DD, 1'b0);
    req_wstrb = 4'hF;
`else
    do_access("full st 08", 1'b1, 32'h08, 32'hAABBCCDD, 32'd0, 1'b0);
    do_access("full ld 08", 1'b0, 32'h08, 32'h0, 32'hAABBCCDD, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, word-organised data memory with a valid/ready request channel and a valid/ready response channel.
- Serves the core's load/store unit with one outstanding access at a time.
- Adds over the earlier data memory: configurable depth and width, byte addressing with alignment and range checks, write acknowledgement, and response back-pressure.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH_LOG2, 3, log2 of the number of words; the memory holds 2**DEPTH_LOG2 words.
- ADDR_WIDTH, 32, byte-address width; must be at least DEPTH_LOG2+log2(DATA_WIDTH/8).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  DATA_WIDTH/8  byte strobes; exists only with DMEM_BYTE_WRITE_EN.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and for errored accesses.
- resp_err  out  1  access was misaligned or out of range.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is asynchronous and active-low (RSTN).
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0. Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. A handshake (req_valid && req_ready) at edge N latches write, address, data and strobes; next state ACCESS.
  - ACCESS: req_ready=0. At edge N+1 perform the store or capture the load word, set resp_err and resp_valid=1; next state RESP.
  - RESP: req_ready=0. resp_valid, resp_rdata and resp_err are held stable until resp_ready=1 at an edge; then resp_valid=0, resp_rdata=0, resp_err=0; next state IDLE.
- req_ready is decoded combinationally from state only; it never depends on req_valid.
- Latency: response is visible the cycle after edge N+1. Minimum spacing is 3 cycles per access when resp_ready is held high.
- Word index = req_addr[log2(DATA_WIDTH/8) +: DEPTH_LOG2].
- Error conditions:
  - Misaligned: any of the low log2(DATA_WIDTH/8) address bits nonzero.
  - Out of range: any address bit above the index field nonzero.
  - On error: no memory write, resp_rdata=0, resp_err=1.
- Request inputs are ignored outside IDLE; a held req_valid is accepted on the first IDLE edge.
- Loads from never-written words return undefined data; the bench must not check these.
- Reset asserted in ACCESS drops the pending store: memory is unchanged. Reset asserted in RESP discards the response.
- A store followed by a load to the same word returns the new data, since accesses are strictly serialised.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined:
  - req_wstrb port present; only bytes whose strobe is 1 are written.
  - wstrb=0 performs no write but still returns a normal response with resp_err=0.
  - Strobes are ignored for loads.
- Undefined:
  - req_wstrb port absent; every store writes the full word.

Test Plan:
- Reset release, idle: -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store 0xDEADBEEF to addr 0x1C, then load 0x1C, resp_ready held 1:
  - -> store response resp_err=0, resp_rdata=0.
  - -> load response resp_rdata=0xDEADBEEF, visible the cycle after edge N+1.
- Load addr 0x1E (misaligned), then store to 0x20 (out of range for DEPTH_LOG2=3):
  - -> both responses resp_err=1.
  - -> a following load of word 0 returns its prior value.
- Response back-pressure: resp_ready=0 for 5 cycles with req_valid held high:
  - -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout.
  - -> the second request is accepted the first edge after return to IDLE.
- Reset mid-store: RSTN low in ACCESS during a store of 0x12345678 to 0x04 (old value 0x0):
  - -> after reset, a load of 0x04 returns 0x0.
- With DMEM_BYTE_WRITE_EN: word 0x08 holds 0x11223344; store 0xAABBCCDD with wstrb=4'b0101:
  - -> load of 0x08 returns 0x11BB33DD.
  - -> wstrb=0 store leaves 0x11BB33DD.
